mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared 64x8 single-port Memory block (clk, ren, wen, addr, din, dout).
- Serialises requesters A and B onto the Memory port, registers all Memory control signals, and returns read data to the requester that issued the read.
- Sits between the Memory block and two client FSMs that each need read/write access.

Parameters:
- AW, 6, address width (64 entries)
- DW, 8, data width
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, A always wins

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A access request, held stable until gnt_a
- we_a  input  1  A: 1 = write, 0 = read
- addr_a  input  AW  A address
- wdata_a  input  DW  A write data
- gnt_a  output  1  one-cycle pulse: A's access is on the Memory port this cycle
- rvalid_a  output  1  one-cycle pulse: rdata_a is valid
- rdata_a  output  DW  A read data, valid only while rvalid_a=1
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
- mem_ren  output  1  to Memory ren (active-high)
- mem_wen  output  1  to Memory wen (active-high), never high together with mem_ren
- mem_addr  output  AW  to Memory addr
- mem_din  output  DW  to Memory din
- mem_dout  input  DW  from Memory dout; valid the cycle after a mem_ren cycle
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; gnt_*, rvalid_*, mem_ren, mem_wen and busy=0; mem_addr, mem_din and rdata_* = 0; last-grant pointer = B, so A wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: select that requester.
  - Both req: RR_EN=1 selects the requester not granted last; RR_EN=0 selects A.
  - On a selection, at the posedge: latch sel, we, addr and wdata into registers; update the last-grant pointer; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_din come from the latched registers.
  - mem_wen = latched we; mem_ren = !latched we.
  - gnt_<sel> = 1.
  - Memory samples at the end of this cycle.
  - Next state: write goes to IDLE; read goes to RESP.
- RESP (exactly 1 cycle):
  - rvalid_<sel> = 1; rdata_<sel> = mem_dout (combinational pass-through, gated to 0 when not valid).
  - mem_ren and mem_wen = 0.
  - Next state: IDLE.
- Latency from req sampled in IDLE:
  - gnt 1 cycle later.
  - Read: rvalid 2 cycles later.
  - Write: Memory updated at the end of the gnt cycle.
  - Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Request handshake:
  - The requester holds req, we, addr and wdata constant until it sees gnt.
  - In the cycle after gnt, the requester may drop req or present a new request; the arbiter ignores req in ACCESS and RESP.
  - A new request is arbitrated only from IDLE.
- Fairness: with RR_EN=1 and both requesters continuously requesting, grants strictly alternate; no requester waits more than one other access.
- Unrequested side: gnt and rvalid stay 0 during the other side's transaction.
- Address wrap: none; addresses 0 and 63 are passed unchanged.
- Reset mid-operation: the in-flight access is abandoned; an ACCESS write cut by rst_n low before the posedge does not reach Memory (mem_wen forced to 0); no gnt or rvalid pulse is produced afterwards; the requester must re-issue.

Test Plan:
- Reset, then A writes 8'd4 @63 (req_a held): gnt_a one cycle after req is sampled, mem_wen=1, mem_addr=63, mem_din=4, busy=1 for that cycle only.
- B writes 8'd77 @26, then B reads @26: rvalid_b 2 cycles after the read request is sampled, rdata_b=77, rvalid_a stays 0.
- req_a and req_b asserted together out of reset, both reads (@63 and @26), both held: gnt_a first, then gnt_b; rdata_a=4, rdata_b=77.
- Both requesters continuously request 6 accesses each with RR_EN=1: grant sequence A,B,A,B,...; with RR_EN=0 and req_a never dropped, gnt_b never asserted.
- Write 8'd35 @8, then write 8'd99 @8 with rst_n pulsed low during its ACCESS cycle, then read @8: rdata=35; no gnt or rvalid during reset; all outputs 0.
- Read @0 and @45 after writing 0 and 8: mem_ren and mem_wen are never high together; rdata_* is 0 whenever rvalid_* is 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter/sequencer for a single-port 64x8 memory
module mem_arbiter #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nx;
    logic          sel_b;
    logic          we_r;
    logic          last_b;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          pick;
    logic          pick_b;

    // On a tie, round-robin hands the port to whoever was not served last.
    always_comb begin
        pick   = req_a | req_b;
        pick_b = req_b;
        if (req_a && req_b) begin
            pick_b = RR_EN ? !last_b : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_b   <= 1'b0;
            we_r    <= 1'b0;
            last_b  <= 1'b1;
            addr_r  <= '0;
            wdata_r <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick) begin
                sel_b   <= pick_b;
                last_b  <= pick_b;
                we_r    <= pick_b ? we_b : we_a;
                addr_r  <= pick_b ? addr_b : addr_a;
                wdata_r <= pick_b ? wdata_b : wdata_a;
            end
        end
    end

    // Memory strobes decode from registered state only, so reset drops them immediately.
    always_comb begin
        state_nx = state;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        rvalid_a = 1'b0;
        rvalid_b = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        case (state)
            IDLE: begin
                if (pick) state_nx = ACCESS;
            end
            ACCESS: begin
                gnt_a    = !sel_b;
                gnt_b    = sel_b;
                mem_wen  = we_r;
                mem_ren  = !we_r;
                state_nx = we_r ? IDLE : RESP;
            end
            RESP: begin
                rvalid_a = !sel_b;
                rvalid_b = sel_b;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr = addr_r;
    assign mem_din  = wdata_r;
    assign rdata_a  = rvalid_a ? mem_dout : '0;
    assign rdata_b  = rvalid_b ? mem_dout : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [5:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_ren, mem_wen, busy;
    logic [5:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = '0;

    logic       fix_req_a = 1'b0, fix_req_b = 1'b0;
    logic       fix_gnt_a, fix_rvalid_a, fix_gnt_b, fix_rvalid_b;
    logic [7:0] fix_rdata_a, fix_rdata_b;
    logic       fix_ren, fix_wen, fix_busy;
    logic [5:0] fix_addr;
    logic [7:0] fix_din;
    logic [7:0] fix_dout = '0;

    logic [7:0] mem_arr [64];
    logic [7:0] ref_mem [64];
    bit         written [64];
    bit         last_b = 1'b1;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(6), .DW(8), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    mem_arbiter #(.AW(6), .DW(8), .RR_EN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req_a(fix_req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(fix_gnt_a), .rvalid_a(fix_rvalid_a), .rdata_a(fix_rdata_a),
        .req_b(fix_req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(fix_gnt_b), .rvalid_b(fix_rvalid_b), .rdata_b(fix_rdata_b),
        .mem_ren(fix_ren), .mem_wen(fix_wen), .mem_addr(fix_addr),
        .mem_din(fix_din), .mem_dout(fix_dout), .busy(fix_busy)
    );

    // Single-port memory behind the arbiter: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem_arr[mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        check("ren_wen_exclusive", int'(mem_ren & mem_wen), 0);
        if (!rvalid_a) check("rdata_a_gated", int'(rdata_a), 0);
        if (!rvalid_b) check("rdata_b_gated", int'(rdata_b), 0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        last_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction per enabled side; grant order and cycle timing come from the arbitration rules.
    task automatic access(input bit ea, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                          input bit eb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
        bit         first_b, pa, pb, rva, rvb;
        int         ga, gb;
        logic [7:0] xa, xb;
        first_b = (ea && eb) ? !last_b : eb;
        ga = 0;
        gb = 0;
        if (ea && eb) begin
            if (first_b) begin gb = 1; ga = wb ? 3 : 4; end
            else begin ga = 1; gb = wa ? 3 : 4; end
        end else if (ea) ga = 1;
        else if (eb) gb = 1;
        req_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
        pa = ea; pb = eb; rva = 0; rvb = 0; xa = '0; xb = '0;
        for (int cyc = 1; cyc <= 12 && (pa || pb || rva || rvb); cyc++) begin
            @(negedge clk);
            check("busy", int'(busy), int'((cyc == ga) || (cyc == gb) || rva || rvb));
            check("rvalid_a", int'(rvalid_a), int'(rva));
            check("rvalid_b", int'(rvalid_b), int'(rvb));
            if (rva) check("rdata_a", int'(rdata_a), int'(xa));
            if (rvb) check("rdata_b", int'(rdata_b), int'(xb));
            rva = 0;
            rvb = 0;
            check("gnt_a", int'(gnt_a), int'(cyc == ga));
            check("gnt_b", int'(gnt_b), int'(cyc == gb));
            if (gnt_a && pa) begin
                check("a_mem_wen", int'(mem_wen), int'(wa));
                check("a_mem_ren", int'(mem_ren), int'(!wa));
                check("a_mem_addr", int'(mem_addr), int'(aa));
                if (wa) begin
                    check("a_mem_din", int'(mem_din), int'(da));
                    ref_mem[aa] = da;
                    written[aa] = 1'b1;
                end else begin
                    rva = 1;
                    xa = ref_mem[aa];
                end
                pa = 0; req_a = 1'b0; last_b = 1'b0;
            end
            if (gnt_b && pb) begin
                check("b_mem_wen", int'(mem_wen), int'(wb));
                check("b_mem_ren", int'(mem_ren), int'(!wb));
                check("b_mem_addr", int'(mem_addr), int'(ab));
                if (wb) begin
                    check("b_mem_din", int'(mem_din), int'(db));
                    ref_mem[ab] = db;
                    written[ab] = 1'b1;
                end else begin
                    rvb = 1;
                    xb = ref_mem[ab];
                end
                pb = 0; req_b = 1'b0; last_b = 1'b1;
            end
        end
        check("a_served", int'(pa), 0);
        check("b_served", int'(pb), 0);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_gnt", int'(gnt_a | gnt_b | rvalid_a | rvalid_b), 0);
    endtask

    initial begin
        int cnt_a, cnt_b;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            written[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_gnt", int'(gnt_a | gnt_b), 0);
        check("rst_rvalid", int'(rvalid_a | rvalid_b), 0);
        check("rst_mem_ctl", int'(mem_ren | mem_wen), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_din", int'(mem_din), 0);
        rst_n = 1'b1;

        access(1, 1, 6'd63, 8'd4, 0, 0, 6'd0, 8'd0);
        access(0, 0, 6'd0, 8'd0, 1, 1, 6'd26, 8'd77);
        access(0, 0, 6'd0, 8'd0, 1, 0, 6'd26, 8'd0);

        do_reset();
        access(1, 0, 6'd63, 8'd0, 1, 0, 6'd26, 8'd0);

        for (int i = 0; i < 6; i++)
            access(1, i[0], 6'(i + 1), 8'($urandom), 1, !i[0], 6'(i + 40), 8'($urandom));

        do_reset();
        we_a = 1'b0; we_b = 1'b0; addr_a = 6'd3; addr_b = 6'd4;
        cnt_a = 0; cnt_b = 0;
        fix_req_a = 1'b1; fix_req_b = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cnt_a += int'(fix_gnt_a);
            cnt_b += int'(fix_gnt_b);
        end
        fix_req_a = 1'b0; fix_req_b = 1'b0;
        check("fix_gnt_b_never", cnt_b, 0);
        check("fix_gnt_a_count", cnt_a, 10);
        repeat (3) @(negedge clk);

        access(1, 1, 6'd8, 8'd35, 0, 0, 6'd0, 8'd0);
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd8; wdata_a = 8'd99;
        @(negedge clk);
        check("cut_gnt_seen", int'(gnt_a), 1);
        rst_n = 1'b0;
        req_a = 1'b0;
        last_b = 1'b1;
        #1;
        check("cut_mem_wen", int'(mem_wen), 0);
        check("cut_gnt", int'(gnt_a), 0);
        check("cut_busy", int'(busy), 0);
        check("cut_mem_addr", int'(mem_addr), 0);
        check("cut_mem_din", int'(mem_din), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("cut_outputs", int'(gnt_a | gnt_b | rvalid_a | rvalid_b | mem_ren | mem_wen | busy), 0);
        end
        rst_n = 1'b1;
        access(1, 0, 6'd8, 8'd0, 0, 0, 6'd0, 8'd0);

        access(1, 1, 6'd0, 8'd0, 1, 1, 6'd45, 8'd8);
        access(1, 0, 6'd0, 8'd0, 1, 0, 6'd45, 8'd0);

        for (int i = 0; i < 40; i++) begin
            bit         ea, eb, wa, wb;
            logic [5:0] aa, ab;
            ea = 1'($urandom_range(0, 1));
            eb = ea ? 1'($urandom_range(0, 1)) : 1'b1;
            wa = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            aa = 6'($urandom_range(0, 63));
            ab = 6'($urandom_range(0, 63));
            if (!wa && !written[aa]) wa = 1'b1;
            if (!wb && !written[ab]) wb = 1'b1;
            access(ea, wa, aa, 8'($urandom), eb, wb, ab, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
